rd_buffer_flow_ctrl: RTL and testbench

- Flow controller that sequences one dual-port read-return buffer between the PHY (write side) and the cache/frontend (read side).
- Owns slot reservation, so a DRAM read burst is only issued when the buffer has room for the whole burst.
- Generates the buffer's write/read enables and pointers. It guarantees a read and a write never target the same address in one cycle.
- Converts the buffer's 1-cycle registered read data into a valid/ready stream with a last-beat marker.

---
 rtl/rd_buffer_flow_ctrl_pkg.sv | 15 +
 rtl/rd_buffer_out_stage.sv | 45 ++++
 rtl/rd_buffer_flow_ctrl.sv | 111 +++++++++++
 tb/tb_rd_buffer_flow_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_buffer_flow_ctrl_pkg.sv
// Shared constants and parameter sanity checks for the read-return buffer
// flow controller and the command scheduler that issues DRAM read bursts.
package rd_buffer_flow_ctrl_pkg;

  // Beats per DRAM read burst; the scheduler sizes its commands from this too.
  localparam int unsigned BURST_LEN    = 4;
  localparam int unsigned BUFFER_DEPTH = 8;

  // Depth must be a power of two (natural pointer wrap) and hold whole bursts.
  function automatic logic params_ok(input int unsigned depth, input int unsigned burst);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (burst >= 1) && ((depth % burst) == 0);
  endfunction

endpackage

// File: rtl/rd_buffer_out_stage.sv
// Output stage of the read-return buffer: owns the valid/ready handshake on
// the buffer's registered read data, the read permission and the burst marker.
module rd_buffer_out_stage
  import rd_buffer_flow_ctrl_pkg::*;
#(
  parameter int unsigned BurstLen = BURST_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic occ_nz,
  input  logic out_ready,
  output logic buf_re,
  output logic out_valid,
  output logic out_last
);

  localparam int unsigned BeatW = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BurstLen - 1);

  logic [BeatW-1:0] rbeat;

  // A read is only issued when the data register is free or being drained,
  // so rdata stays stable while the consumer stalls.
  assign buf_re   = occ_nz && (!out_valid || out_ready);
  assign out_last = out_valid && (rbeat == LastBeat);

  // Data register holds a beat from the cycle after a read until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      out_valid <= 1'b0;
    else if (buf_re)
      out_valid <= 1'b1;
    else if (out_ready)
      out_valid <= 1'b0;
  end

  // Beat index within the current output burst, advanced per accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rbeat <= '0;
    else if (out_valid && out_ready)
      rbeat <= (rbeat == LastBeat) ? '0 : rbeat + BeatW'(1);
  end

endmodule

// File: rtl/rd_buffer_flow_ctrl.sv
// Flow controller for the dual-port read-return buffer between the PHY and
// the cache frontend: reserves whole-burst slots before a DRAM read is issued,
// drives the buffer's write/read ports and exposes a valid/ready output.
module rd_buffer_flow_ctrl
  import rd_buffer_flow_ctrl_pkg::*;
#(
  parameter int unsigned BufferDepth = BUFFER_DEPTH,
  parameter int unsigned BurstLen    = BURST_LEN,
  localparam int unsigned PtrW = $clog2(BufferDepth),
  localparam int unsigned CntW = $clog2(BufferDepth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  output logic            alloc_gnt,
  input  logic            phy_valid,
  output logic            buf_we,
  output logic [PtrW-1:0] buf_wptr,
  output logic            buf_re,
  output logic [PtrW-1:0] buf_rptr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [CntW-1:0] occupancy,
  output logic            ovf_err
);

  if (!params_ok(BufferDepth, BurstLen)) begin : g_param_err
    $error("rd_buffer_flow_ctrl: BufferDepth must be a power of 2 and a multiple of BurstLen");
  end

  localparam logic [CntW-1:0] Depth  = CntW'(BufferDepth);
  localparam logic [CntW-1:0] Burst  = CntW'(BurstLen);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [PtrW-1:0] wptr, rptr;
  logic [CntW-1:0] occ, resv, pend;
  logic [CntW-1:0] occ_nxt, resv_nxt, pend_nxt;

  assign alloc_gnt = alloc_req && ((Depth - resv) >= Burst);
  assign buf_we    = phy_valid && (pend != '0);
  assign buf_wptr  = wptr;
  assign buf_rptr  = rptr;
  assign occupancy = occ;

  rd_buffer_out_stage #(
    .BurstLen (BurstLen)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .occ_nz    (occ != '0),
    .out_ready (out_ready),
    .buf_re    (buf_re),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  // Grant, write and read each contribute their own delta so any combination
  // in one cycle resolves without ordering hazards.
  always_comb begin
    occ_nxt  = occ;
    resv_nxt = resv;
    pend_nxt = pend;
    if (alloc_gnt) begin
      resv_nxt = resv_nxt + Burst;
      pend_nxt = pend_nxt + Burst;
    end
    if (buf_we) begin
      pend_nxt = pend_nxt - CntOne;
      occ_nxt  = occ_nxt + CntOne;
    end
    if (buf_re) begin
      resv_nxt = resv_nxt - CntOne;
      occ_nxt  = occ_nxt - CntOne;
    end
  end

  // Occupancy, reservation and pending-beat counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ  <= '0;
      resv <= '0;
      pend <= '0;
    end else begin
      occ  <= occ_nxt;
      resv <= resv_nxt;
      pend <= pend_nxt;
    end
  end

  // Buffer write/read pointers with natural wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (buf_we) wptr <= wptr + PtrOne;
      if (buf_re) rptr <= rptr + PtrOne;
    end
  end

  // Sticky flag for a PHY beat that arrived without an outstanding reservation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf_err <= 1'b0;
    else if (phy_valid && (pend == '0))
      ovf_err <= 1'b1;
  end

endmodule

// File: tb/tb_rd_buffer_flow_ctrl.sv
// Testbench for rd_buffer_flow_ctrl with a behavioural dual-port buffer
// (registered read) and a scoreboard of beats in write order.
module tb_rd_buffer_flow_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned BL    = 4;
  localparam int          PW    = 3;
  localparam int          CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_gnt;
  logic          phy_valid;
  logic [15:0]   phy_data;
  logic          buf_we;
  logic [PW-1:0] buf_wptr;
  logic          buf_re;
  logic [PW-1:0] buf_rptr;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] occupancy;
  logic          ovf_err;

  always #5 clk = ~clk;

  rd_buffer_flow_ctrl #(
    .BufferDepth (DEPTH),
    .BurstLen    (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .phy_valid (phy_valid),
    .buf_we    (buf_we),
    .buf_wptr  (buf_wptr),
    .buf_re    (buf_re),
    .buf_rptr  (buf_rptr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .occupancy (occupancy),
    .ovf_err   (ovf_err)
  );

  // Behavioural dual-port buffer with 1-cycle registered read data.
  logic [15:0] mem [DEPTH];
  logic [15:0] rdata;
  always @(posedge clk) begin
    if (buf_we) mem[buf_wptr] <= phy_data;
    if (buf_re) rdata <= mem[buf_rptr];
  end

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t         sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   seq = 16'h0100;
  int unsigned   push_beat = 0;
  logic [PW-1:0] exp_wptr = '0;

  // Output monitor: accepted beats against the scoreboard, plus hazard watch.
  always @(negedge clk) begin
    beat_t e;
    if (rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_underflow: beat accepted data=%h with nothing expected", rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.data || out_last !== e.last) begin
          errors++;
          $display("FAIL out_beat: got data=%h last=%b, expected data=%h last=%b",
                   rdata, out_last, e.data, e.last);
        end
      end
    end
    if (buf_we && buf_re) begin
      checks++;
      if (buf_wptr == buf_rptr) begin
        errors++;
        $display("FAIL rw_hazard: we and re both at address %0d, required distinct", buf_wptr);
      end
    end
  end

  // One alloc_req cycle with the expected grant; returns at the next cycle.
  task automatic do_alloc(input logic exp_gnt, input string name);
    alloc_req = 1'b1;
    #1;
    checks++;
    if (alloc_gnt !== exp_gnt) begin
      errors++;
      $display("FAIL %s: alloc_gnt=%b, expected %b", name, alloc_gnt, exp_gnt);
    end
    @(posedge clk); #1;
    alloc_req = 1'b0;
  endtask

  // Drive n reserved PHY beats on consecutive cycles.
  task automatic drive_beats(input int n, input logic push, input string name);
    for (int i = 0; i < n; i++) begin
      phy_valid = 1'b1;
      phy_data  = seq;
      #1;
      checks++;
      if (buf_we !== 1'b1 || buf_wptr !== exp_wptr) begin
        errors++;
        $display("FAIL %s_write: buf_we=%b buf_wptr=%0d, expected buf_we=1 buf_wptr=%0d",
                 name, buf_we, buf_wptr, exp_wptr);
      end
      if (push) begin
        sb.push_back('{data: seq, last: (push_beat == BL - 1)});
        push_beat = (push_beat + 1) % BL;
      end
      exp_wptr = exp_wptr + PW'(1);
      seq = seq + 16'd1;
      @(posedge clk); #1;
    end
    phy_valid = 1'b0;
  endtask

  // Wait (bounded) for all expected beats to be consumed, then check idle.
  task automatic wait_drain(input int bound, input string name);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats still outstanding, expected 0", name, sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== '0) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%b occupancy=%0d, expected 0 and 0",
               name, out_valid, occupancy);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({alloc_gnt, buf_we, buf_wptr, buf_re, buf_rptr, out_valid, out_last,
         occupancy, ovf_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b we=%b wptr=%0d re=%b rptr=%0d valid=%b last=%b occ=%0d ovf=%b, expected all 0",
               alloc_gnt, buf_we, buf_wptr, buf_re, buf_rptr, out_valid, out_last, occupancy, ovf_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    logic exp_v, exp_l;
    out_ready = 1'b1;
    do_alloc(1'b1, "single_gnt");
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        phy_valid = 1'b1;
        phy_data  = seq;
      end else begin
        phy_valid = 1'b0;
      end
      #1;
      if (c < 4) begin
        checks++;
        if (buf_we !== 1'b1 || buf_wptr !== exp_wptr) begin
          errors++;
          $display("FAIL single_write: buf_we=%b buf_wptr=%0d, expected 1 and %0d",
                   buf_we, buf_wptr, exp_wptr);
        end
        sb.push_back('{data: seq, last: (push_beat == BL - 1)});
        push_beat = (push_beat + 1) % BL;
        exp_wptr = exp_wptr + PW'(1);
        seq = seq + 16'd1;
      end
      exp_v = (c >= 2 && c <= 5);
      exp_l = (c == 5);
      checks++;
      if (out_valid !== exp_v || out_last !== exp_l) begin
        errors++;
        $display("FAIL single_timing c=%0d: out_valid=%b out_last=%b, expected %b %b",
                 c, out_valid, out_last, exp_v, exp_l);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (occupancy !== '0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_final: occupancy=%0d outstanding=%0d, expected 0 and 0",
               occupancy, sb.size());
    end
  endtask

  task automatic test_reservation_limit();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1;
      #1;
      checks++;
      if (alloc_gnt !== (i < 2)) begin
        errors++;
        $display("FAIL resv_gnt%0d: alloc_gnt=%b, expected %b", i, alloc_gnt, (i < 2));
      end
      @(posedge clk); #1;
    end
    alloc_req = 1'b0;
    drive_beats(8, 1'b1, "resv");
    @(posedge clk); #1;
    // One beat sits in the data register, so only one slot is free.
    alloc_req = 1'b1;
    #1;
    checks++;
    if (alloc_gnt !== 1'b0 || occupancy !== CW'(7) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL resv_retry: gnt=%b occ=%0d valid=%b, expected 0 7 1",
               alloc_gnt, occupancy, out_valid);
    end
    @(posedge clk); #1;
    alloc_req = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      #1;
      checks++;
      if (buf_re !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b0 || rdata !== sb[0].data) begin
        errors++;
        $display("FAIL bp_hold%0d: re=%b valid=%b last=%b rdata=%h, expected 0 1 0 %h",
                 i, buf_re, out_valid, out_last, rdata, sb[0].data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      alloc_req = 1'b1;
      #1;
      checks++;
      if (alloc_gnt !== (r == 3)) begin
        errors++;
        $display("FAIL bp_regrant%0d: alloc_gnt=%b, expected %b", r, alloc_gnt, (r == 3));
      end
      @(posedge clk); #1;
    end
    alloc_req = 1'b0;
    drive_beats(4, 1'b1, "bp");
    wait_drain(40, "bp_drain");
  endtask

  task automatic test_wrap();
    int left = 5;
    int pending = 0;
    int n = 0;
    while ((left > 0 || pending > 0 || sb.size() != 0) && n < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      alloc_req = (left > 0);
      phy_valid = (pending > 0) && 1'($urandom_range(0, 1));
      phy_data  = seq;
      #1;
      if (alloc_req && alloc_gnt) begin
        left--;
        pending += BL;
      end
      if (phy_valid) begin
        checks++;
        if (buf_we !== 1'b1 || buf_wptr !== exp_wptr) begin
          errors++;
          $display("FAIL wrap_write: buf_we=%b buf_wptr=%0d, expected 1 and %0d",
                   buf_we, buf_wptr, exp_wptr);
        end
        sb.push_back('{data: seq, last: (push_beat == BL - 1)});
        push_beat = (push_beat + 1) % BL;
        exp_wptr = exp_wptr + PW'(1);
        seq = seq + 16'd1;
        pending--;
      end
      @(posedge clk); #1;
      n++;
    end
    alloc_req = 1'b0;
    phy_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (left != 0 || pending != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_timeout: bursts_left=%0d pending=%0d outstanding=%0d, expected 0 0 0",
               left, pending, sb.size());
    end
    wait_drain(20, "wrap_drain");
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre: ovf_err=%b, expected 0", ovf_err);
    end
    phy_valid = 1'b1;
    phy_data  = 16'hdead;
    #1;
    checks++;
    if (buf_we !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop: buf_we=%b, expected 0", buf_we);
    end
    @(posedge clk); #1;
    phy_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ovf_err !== 1'b1) begin
        errors++;
        $display("FAIL ovf_sticky%0d: ovf_err=%b, expected 1", i, ovf_err);
      end
      @(posedge clk); #1;
    end
    do_alloc(1'b1, "ovf_gnt");
    drive_beats(4, 1'b1, "ovf");
    wait_drain(30, "ovf_drain");
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: ovf_err=%b, expected 1", ovf_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1'b0;
    do_alloc(1'b1, "rst_gnt");
    drive_beats(2, 1'b0, "rst_pre");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({alloc_gnt, buf_we, buf_wptr, buf_re, buf_rptr, out_valid, out_last,
         occupancy, ovf_err} !== '0) begin
      errors++;
      $display("FAIL rst_async: gnt=%b we=%b wptr=%0d re=%b rptr=%0d valid=%b last=%b occ=%0d ovf=%b, expected all 0",
               alloc_gnt, buf_we, buf_wptr, buf_re, buf_rptr, out_valid, out_last, occupancy, ovf_err);
    end
    sb.delete();
    exp_wptr  = '0;
    push_beat = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_alloc(1'b1, "rst_regrant");
    drive_beats(4, 1'b1, "rst_post");
    wait_drain(30, "rst_drain");
  endtask

  initial begin
    rst       = 1'b0;
    alloc_req = 1'b0;
    phy_valid = 1'b0;
    phy_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_burst();
    test_reservation_limit();
    test_backpressure();
    test_wrap();
    test_overflow();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
